data_upload: RTL and testbench

DATA_UPLOAD -- requirements
Module: data_upload

---
 rtl/data_upload_pkg.sv | 18 +
 rtl/spi_edge_sync.sv | 35 +++
 rtl/data_upload.sv | 141 ++++++++++++++
 tb/tb_data_upload.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_upload_pkg.sv
// Shared opcodes, data-path states and filler byte for the SPI upload block.
package data_upload_pkg;

  localparam logic [7:0] UL_BEGIN   = 8'h60;
  localparam logic [7:0] UL_END     = 8'h61;
  localparam logic [7:0] UL_READ    = 8'h62;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_DESEL,
    ST_CMD,
    ST_INDEX,
    ST_DUMMY,
    ST_STREAM,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings SCK/SS/DI into clk_sys through two flops each and flags SCK edges.
module spi_edge_sync (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic sck,
  input  logic ss,
  input  logic di,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_s,
  output logic di_s
);

  // bit order {sck, ss, di}; SS resets high so the block starts deselected
  logic [2:0] meta_q, sync_q;
  logic       sck_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 3'b010;
      sync_q <= 3'b010;
      sck_q  <= 1'b0;
    end else begin
      meta_q <= {sck, ss, di};
      sync_q <= meta_q;
      sck_q  <= sync_q[2];
    end
  end

  assign sck_rise = sync_q[2] & ~sck_q;
  assign sck_fall = ~sync_q[2] & sck_q;
  assign ss_s     = sync_q[1];
  assign di_s     = sync_q[0];

endmodule

// File: rtl/data_upload.sv
// SPI slave that streams host-memory bytes (fetched over ioctl_rd/ack) out on MISO.
module data_upload
  import data_upload_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_DI,
  output wire               SPI_DO,
  output logic              ioctl_upload,
  output logic [7:0]        ioctl_index,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic              ioctl_rd,
  input  logic              ioctl_ack,
  input  logic [7:0]        ioctl_din,
  output logic              ioctl_err
);

  logic sck_rise, sck_fall, ss_s, di_s;

  spi_edge_sync u_sync (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .sck      (SPI_SCK),
    .ss       (SPI_SS2),
    .di       (SPI_DI),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_s     (ss_s),
    .di_s     (di_s)
  );

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;
  logic [7:0] buf_q;
  logic       buf_vld;

  logic [7:0] rx_byte;
  logic       byte_end;
  logic       ack_hit;

  assign rx_byte  = {rx_sr, di_s};
  assign byte_end = sck_rise && (bit_cnt == 3'd7);
  assign ack_hit  = ioctl_rd && ioctl_ack;

  assign SPI_DO = (SPI_SS2 || !reset_n) ? 1'bz : tx_sr[7];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_DESEL;
      bit_cnt      <= 3'd0;
      rx_sr        <= 7'd0;
      tx_sr        <= 8'd0;
      buf_q        <= 8'd0;
      buf_vld      <= 1'b0;
      ioctl_upload <= 1'b0;
      ioctl_index  <= 8'd0;
      ioctl_addr   <= '0;
      ioctl_rd     <= 1'b0;
      ioctl_err    <= 1'b0;
    end else begin
      if (ack_hit) begin
        buf_q    <= ioctl_din;
        buf_vld  <= 1'b1;
        ioctl_rd <= 1'b0;
      end

      if (ss_s) begin
        // a byte already in the shifter never made it out; resume from it
        if (state == ST_STREAM) ioctl_addr <= ioctl_addr - ADDR_W'(1);
        state   <= ST_DESEL;
        bit_cnt <= 3'd0;
        tx_sr   <= 8'd0;
        buf_vld <= 1'b0;
      end else begin
        if (state == ST_DESEL) state <= ST_CMD;

        // no shift right after a load, so the fresh MSB survives the falling edge
        if (sck_fall && bit_cnt != 3'd0) tx_sr <= {tx_sr[6:0], 1'b0};

        if (sck_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx_sr   <= rx_byte[6:0];
        end

        if (byte_end) begin
          case (state)
            ST_CMD: begin
              case (rx_byte)
                UL_BEGIN: begin
                  state     <= ST_INDEX;
                  ioctl_err <= 1'b0;
                end
                UL_END: begin
                  ioctl_upload <= 1'b0;
                  state        <= ST_IGNORE;
                end
                UL_READ: begin
                  if (ioctl_upload) begin
                    state    <= ST_DUMMY;
                    ioctl_rd <= 1'b1;
                    buf_vld  <= 1'b0;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end
                default: state <= ST_IGNORE;
              endcase
            end
            ST_INDEX: begin
              ioctl_index  <= rx_byte;
              ioctl_upload <= 1'b1;
              ioctl_addr   <= '0;
              state        <= ST_IGNORE;
            end
            ST_DUMMY, ST_STREAM: begin
              // ack landing on the boundary itself is forwarded straight to the shifter
              if (buf_vld)      tx_sr <= buf_q;
              else if (ack_hit) tx_sr <= ioctl_din;
              else begin
                tx_sr     <= DUMMY_BYTE;
                ioctl_err <= 1'b1;
              end
              ioctl_addr <= ioctl_addr + ADDR_W'(1);
              buf_vld    <= 1'b0;
              ioctl_rd   <= 1'b1;
              state      <= ST_STREAM;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_data_upload.sv
// Randomised bench: SPI host + host-memory responder, checked against a byte-level model.
module tb_data_upload;

  localparam int AW       = 5;    // narrow address so the wrap is reachable by streaming
  localparam int HALF     = 80;   // SCK half period = 8 clk_sys cycles
  localparam int SLOW_LAT = 200;  // longer than one byte time
  localparam logic [7:0] OP_BEGIN = 8'h60;
  localparam logic [7:0] OP_END   = 8'h61;
  localparam logic [7:0] OP_READ  = 8'h62;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          SPI_SCK = 1'b0;
  logic          SPI_SS2 = 1'b1;
  logic          SPI_DI  = 1'b0;
  wire           SPI_DO;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic [AW-1:0] ioctl_addr;
  logic          ioctl_rd;
  logic          ioctl_ack = 1'b0;
  logic [7:0]    ioctl_din = 8'h00;
  logic          ioctl_err;

  logic [7:0] mem [32];
  int checks = 0;
  int errors = 0;
  int ack_lat = 3;
  int slow_req = 0;
  int slow_done = 0;

  // reference model: what the host-visible outputs should read
  logic          m_upload;
  logic [7:0]    m_index;
  logic [AW-1:0] m_addr;
  logic          m_err;

  always #5 clk_sys = ~clk_sys;

  data_upload #(.ADDR_W(AW)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .SPI_SCK      (SPI_SCK),
    .SPI_SS2      (SPI_SS2),
    .SPI_DI       (SPI_DI),
    .SPI_DO       (SPI_DO),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_addr   (ioctl_addr),
    .ioctl_rd     (ioctl_rd),
    .ioctl_ack    (ioctl_ack),
    .ioctl_din    (ioctl_din),
    .ioctl_err    (ioctl_err)
  );

  // host memory: answers each read after a latency with the byte at the current address
  initial begin
    int lat;
    forever begin
      @(posedge clk_sys);
      if (ioctl_rd) begin
        lat = ack_lat;
        if (slow_done < slow_req) begin
          lat = SLOW_LAT;
          slow_done++;
        end
        repeat (lat) @(posedge clk_sys);
        #1;
        ioctl_ack = 1'b1;
        ioctl_din = mem[ioctl_addr];
        @(posedge clk_sys);
        #1;
        ioctl_ack = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs();
    chk("upload", 32'(ioctl_upload), 32'(m_upload));
    chk("index",  32'(ioctl_index),  32'(m_index));
    chk("addr",   32'(ioctl_addr),   32'(m_addr));
    chk("err",    32'(ioctl_err),    32'(m_err));
  endtask

  task automatic model_reset();
    m_upload = 1'b0;
    m_index  = 8'h00;
    m_addr   = '0;
    m_err    = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      SPI_DI = tx[i];
      #(HALF);
      rx[i] = SPI_DO;
      SPI_SCK = 1'b1;
      #(HALF);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic select();
    SPI_SS2 = 1'b0;
    #(2*HALF);
  endtask

  task automatic deselect();
    #(HALF);
    SPI_SS2 = 1'b1;
    #(4*HALF);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ioctl_rd && n < 1000) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    chk("rd_settled", 32'(ioctl_rd), 32'd0);
  endtask

  task automatic do_begin(input logic [7:0] idx);
    logic [7:0] r;
    select();
    spi_byte(OP_BEGIN, r);
    chk("begin_cmd_do", 32'(r), 32'd0);
    spi_byte(idx, r);
    chk("begin_idx_do", 32'(r), 32'd0);
    deselect();
    m_upload = 1'b1;
    m_index  = idx;
    m_addr   = '0;
    m_err    = 1'b0;
    wait_idle();
    check_outs();
  endtask

  task automatic do_cmd(input logic [7:0] op);
    logic [7:0] r;
    select();
    spi_byte(op, r);
    chk("cmd_do", 32'(r), 32'd0);
    spi_byte(8'($urandom), r);
    chk("cmd_tail_do", 32'(r), 32'd0);
    deselect();
    if (op == OP_END) m_upload = 1'b0;
    wait_idle();
    check_outs();
  endtask

  // UL_READ, dummy byte, then n streamed bytes; slow makes the first fetch miss its slot
  task automatic do_read(input int n, input bit slow, input bit chk_pend);
    logic [7:0]    r, exp;
    logic [AW-1:0] a;
    if (slow) slow_req++;
    select();
    spi_byte(OP_READ, r);
    chk("read_cmd_do", 32'(r), 32'd0);
    spi_byte(8'($urandom), r);
    chk("dummy_do", 32'(r), 32'd0);
    for (int j = 1; j <= n; j++) begin
      spi_byte(8'($urandom), r);
      a = m_addr + AW'(j - 1);
      if (!m_upload || (slow && j == 1)) exp = 8'h00;
      else exp = mem[a];
      chk("stream_do", 32'(r), 32'(exp));
    end
    if (chk_pend) begin
      #1;
      chk("fetch_pending", 32'(ioctl_rd), 32'd1);
    end
    deselect();
    wait_idle();
    if (m_upload) begin
      m_addr = m_addr + AW'(n);
      if (slow) m_err = 1'b1;
    end
    check_outs();
  endtask

  initial begin
    logic [7:0] r, op;
    mem[0] = 8'hA1;
    mem[1] = 8'hB2;
    mem[2] = 8'hC3;
    mem[3] = 8'hD4;
    for (int i = 4; i < 32; i++) mem[i] = 8'($urandom);

    // reset state
    repeat (4) @(posedge clk_sys);
    #1;
    model_reset();
    check_outs();
    chk("reset_rd", 32'(ioctl_rd), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk_sys);

    do_begin(8'h05);

    ack_lat = 3;
    do_read(4, 1'b0, 1'b0);

    do_begin(8'h11);
    do_read(4, 1'b1, 1'b0);
    do_begin(8'h22);

    ack_lat = 5;
    do_read(31, 1'b0, 1'b0);
    do_read(2, 1'b0, 1'b0);

    do_begin(8'h03);
    ack_lat = 60;
    do_read(2, 1'b0, 1'b1);
    ack_lat = 4;
    do_read(2, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      ack_lat = int'($urandom_range(1, 40));
      case ($urandom_range(0, 3))
        0: do_begin(8'($urandom));
        1: do_read(int'($urandom_range(0, 5)), 1'b0, 1'b0);
        2: do_cmd(OP_END);
        default: begin
          op = 8'($urandom);
          if (op == OP_BEGIN || op == OP_END || op == OP_READ) op = 8'hA5;
          do_cmd(op);
        end
      endcase
    end

    // reset in the middle of a stream with a fetch outstanding
    do_begin(8'h07);
    ack_lat = 60;
    select();
    spi_byte(OP_READ, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    chk("pre_reset_do", 32'(r), 32'(mem[m_addr]));
    #1;
    chk("pre_reset_rd", 32'(ioctl_rd), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("reset_rd_now", 32'(ioctl_rd), 32'd0);
    SPI_SS2 = 1'b1;
    #(4*HALF);
    reset_n = 1'b1;
    repeat (100) @(posedge clk_sys);
    #1;
    chk("late_ack_rd", 32'(ioctl_rd), 32'd0);
    do_read(1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
